// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hold-level codes, halt FSM states, helpers.
package pipe_ctrl_pkg;

  // Hold levels are ordered so that a numerically larger code freezes more of the pipe.
  typedef enum logic [2:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_st_e;

  localparam int CYC_W = 4;

  function automatic logic [2:0] hold_max(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_halt_fsm.sv
// Debug-halt sequencer: drains the pipe for DRAIN_CYC clean cycles, then holds it and acks.
module pipe_ctrl_halt_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_halt_req,
  input  logic       i_jump,
  input  logic       i_flush_busy,
  output logic [2:0] o_halt_lvl,
  output logic       o_halt_ack
);

  localparam logic [CYC_W-1:0] DRAIN_LD = CYC_W'(DRAIN_CYC);

  halt_st_e         r_state;
  halt_st_e         w_state_nxt;
  logic [CYC_W-1:0] r_drain_cnt;
  logic [CYC_W-1:0] w_drain_nxt;
  logic             r_ack;

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    o_halt_lvl  = HOLD_NONE;
    case (r_state)
      ST_RUN: begin
        if (i_halt_req) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DRAIN_LD;
        end
      end
      ST_DRAIN: begin
        o_halt_lvl = HOLD_PC;
        if (!i_halt_req) begin
          w_state_nxt = ST_RUN;
        end else if (i_jump) begin
          w_drain_nxt = DRAIN_LD;
        end else if (!i_flush_busy) begin
          // Only cycles with no flush in flight count as clean drain cycles.
          w_drain_nxt = r_drain_cnt - 4'd1;
          if (r_drain_cnt == 4'd1) w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        o_halt_lvl = HOLD_ID;
        if (!i_halt_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
    if (rst) o_halt_lvl = HOLD_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_ack       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_ack       <= (w_state_nxt == ST_HALTED);
    end
  end

  assign o_halt_ack = r_ack;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: jump pass-through, priority hold resolution, post-jump flush,
// debug halt and a saturating stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_HOLD  = 4,
  parameter int FLUSH_CYC = 1,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_flag_i,
  input  logic [31:0]           jump_addr_i,
  input  logic [NUM_HOLD-1:0]   hold_req_i,
  input  logic [3*NUM_HOLD-1:0] hold_lvl_i,
  input  logic                  halt_req_i,
  input  logic                  cnt_clr_i,
  output logic [2:0]            hold_flag_o,
  output logic                  jump_flag_o,
  output logic [31:0]           jump_addr_o,
  output logic                  halt_ack_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam logic [CYC_W-1:0] FLUSH_LD = CYC_W'(FLUSH_CYC);

  logic [CYC_W-1:0] r_flush_cnt;
  logic             w_flush_busy;
  logic [2:0]       w_ch_lvl;
  logic [2:0]       w_flush_lvl;
  logic [2:0]       w_halt_lvl;
  logic [CNT_W-1:0] r_stall_cnt;

  assign jump_flag_o = jump_flag_i;
  assign jump_addr_o = jump_addr_i;

  always_comb begin
    w_ch_lvl = HOLD_NONE;
    for (int k = 0; k < NUM_HOLD; k++) begin
      if (hold_req_i[k]) w_ch_lvl = hold_max(w_ch_lvl, hold_lvl_i[3*k +: 3]);
    end
  end

  // A live jump flushes even in reset; a stale flush count does not.
  assign w_flush_busy = (r_flush_cnt != '0);
  assign w_flush_lvl  = (jump_flag_i || (w_flush_busy && !rst)) ? HOLD_ID : HOLD_NONE;
  assign hold_flag_o  = hold_max(hold_max(w_ch_lvl, w_flush_lvl), w_halt_lvl);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (jump_flag_i) begin
      r_flush_cnt <= FLUSH_LD;
    end else if (w_flush_busy) begin
      r_flush_cnt <= r_flush_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i) begin
      r_stall_cnt <= '0;
    end else if ((hold_flag_o != HOLD_NONE) && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;

  pipe_ctrl_halt_fsm #(
    .DRAIN_CYC (DRAIN_CYC)
  ) u_halt_fsm (
    .clk          (clk),
    .rst          (rst),
    .i_halt_req   (halt_req_i),
    .i_jump       (jump_flag_i),
    .i_flush_busy (w_flush_busy),
    .o_halt_lvl   (w_halt_lvl),
    .o_halt_ack   (halt_ack_o)
  );

endmodule
